// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package riscv_pkg;

  localparam int          XLEN       = 32;
  localparam int          INSN_BYTES = 4;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_if_pipe_if.sv
// Instruction-memory and decode-side handshake bundle of the fetch stage.
interface riscv_if_pipe_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Small fetch-entry FIFO with flush; push and pop may occur in the same cycle.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop & (count_q != '0);
    push_ok  = push & ((count_q != CW'(DEPTH)) | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/riscv_if_pipe.sv
// Instruction fetch stage: credit-limited imem requests, in-order response
// buffering, and redirect with kill accounting for stale in-flight fetches.
module riscv_if_pipe
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bubble,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        pc,
  riscv_if_pipe_if.master        bus
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DW   = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSN_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   kill_sum;
  logic [XLEN-1:0] target;
  logic            req, grant, resp_keep, resp_drop;
  entry_t          push_entry, head;
  logic            unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  always_comb begin
    target    = {redirect_pc[XLEN-1:2], 2'b00};
    req       = rst & ~redirect & ~bubble
              & ((live_q + count) < DW)
              & ((live_q + kill_q) < DW);
    grant     = req & bus.imem_gnt;
    resp_drop = bus.imem_rvalid & (kill_q != '0);
    resp_keep = bus.imem_rvalid & (kill_q == '0) & (live_q != '0);
  end

  // A redirect turns every live fetch into a kill; a response landing in the
  // same cycle belongs to the old stream and retires one of them.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    live_d    = live_q;
    kill_d    = kill_q;
    kill_sum  = kill_q + live_q;
    if (redirect) begin
      pc_d      = target;
      resp_pc_d = target;
      live_d    = '0;
      if (bus.imem_rvalid && (kill_sum != '0)) kill_sum = kill_sum - CW'(1);
      kill_d    = kill_sum;
    end else begin
      if (grant)     pc_d      = pc_q + STEP;
      if (resp_keep) resp_pc_d = resp_pc_q + STEP;
      live_d = live_q + CW'(grant) - CW'(resp_keep);
      if (resp_drop) kill_d = kill_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      live_q    <= '0;
      kill_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      live_q    <= live_d;
      kill_q    <= kill_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, instr: bus.imem_rdata};

  riscv_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (bus.out_ready),
    .head      (head),
    .count     (count)
  );

  assign pc             = pc_q;
  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.out_valid  = (count != '0);
  assign bus.out_pc     = head.pc;
  assign bus.out_instr  = bus.out_valid ? head.instr : NOP_INSN;

endmodule

// File: tb/tb_riscv_if_pipe.sv
// Directed bench for riscv_if_pipe: a DEPTH=4 instance (reset PC 0) and a
// DEPTH=2 instance (reset PC 0x8000_0000) share stimulus, each with its own imem model.
module tb_riscv_if_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubble, redirect, out_ready, gnt;
  logic [31:0] redirect_pc;
  logic [31:0] pc_a, pc_b;
  int          lat;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] RB = 32'h8000_0000;

  always #5 clk = ~clk;

  riscv_if_pipe_if #(.XLEN(32)) bus_a ();
  riscv_if_pipe_if #(.XLEN(32)) bus_b ();

  riscv_if_pipe #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc_a), .bus(bus_a)
  );

  riscv_if_pipe #(.XLEN(32), .RESET_PC(RB), .DEPTH(2)) u_b (
    .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc_b), .bus(bus_b)
  );

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // imem models: respond in order, lat cycles after each grant
  logic        v_a [1:3];
  logic        v_b [1:3];
  logic [31:0] ad_a [1:3];
  logic [31:0] ad_b [1:3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= 3; k++) begin
        v_a[k] <= 1'b0; ad_a[k] <= '0; v_b[k] <= 1'b0; ad_b[k] <= '0;
      end
    end else begin
      v_a[1]  <= bus_a.imem_req & bus_a.imem_gnt;
      ad_a[1] <= bus_a.imem_addr;
      v_b[1]  <= bus_b.imem_req & bus_b.imem_gnt;
      ad_b[1] <= bus_b.imem_addr;
      for (int k = 2; k <= 3; k++) begin
        v_a[k] <= v_a[k-1]; ad_a[k] <= ad_a[k-1];
        v_b[k] <= v_b[k-1]; ad_b[k] <= ad_b[k-1];
      end
    end
  end

  assign bus_a.imem_gnt    = gnt;
  assign bus_b.imem_gnt    = gnt;
  assign bus_a.imem_rvalid = v_a[lat];
  assign bus_b.imem_rvalid = v_b[lat];
  assign bus_a.imem_rdata  = insn_of(ad_a[lat]);
  assign bus_b.imem_rdata  = insn_of(ad_b[lat]);
  assign bus_a.out_ready   = out_ready;
  assign bus_b.out_ready   = out_ready;

  // A response must always have an outstanding fetch to match.
  always @(posedge clk) begin
    if (rst && bus_a.imem_rvalid) begin
      n_cmp++;
      assert ((u_a.live_q + u_a.kill_q) != 3'd0)
        else begin n_err++; $error("FAIL proto_a: rvalid with live+kill=0"); end
    end
    if (rst && bus_b.imem_rvalid) begin
      n_cmp++;
      assert ((u_b.live_q + u_b.kill_q) != 2'd0)
        else begin n_err++; $error("FAIL proto_b: rvalid with live+kill=0"); end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin n_err++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; bubble = 1'b0; redirect = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; gnt = 1'b1; lat = 1;
    tick(); tick();
    chk("rst_pc_a",  pc_a, 32'h0);
    chk("rst_req_a", bus_a.imem_req, 0);
    chk("rst_ov_a",  bus_a.out_valid, 0);
    chk("rst_pc_b",  pc_b, RB);
    chk("rst_req_b", bus_b.imem_req, 0);

    // streaming, 1-cycle response latency
    rst = 1'b1; #1;
    chk("c0_req", bus_a.imem_req, 1);
    chk("c0_pc",  pc_a, 32'h0);
    tick();
    chk("c1_pc", pc_a, 32'h4);
    chk("c1_ov", bus_a.out_valid, 0);
    tick();
    chk("c2_pc",    pc_a, 32'h8);
    chk("c2_ov",    bus_a.out_valid, 1);
    chk("c2_opc",   bus_a.out_pc, 32'h0);
    chk("c2_instr", bus_a.out_instr, insn_of(32'h0));
    tick();
    chk("c3_pc",    pc_a, 32'hC);
    chk("c3_opc",   bus_a.out_pc, 32'h4);
    chk("c3_instr", bus_a.out_instr, insn_of(32'h4));

    // bubble for two cycles at pc=12
    bubble = 1'b1; #1;
    chk("bub_req0", bus_a.imem_req, 0);
    tick();
    chk("bub_pc1",  pc_a, 32'hC);
    chk("bub_req1", bus_a.imem_req, 0);
    chk("bub_opc",  bus_a.out_pc, 32'h8);
    chk("bub_ov",   bus_a.out_valid, 1);
    tick();
    chk("bub_pc2",  pc_a, 32'hC);
    chk("bub_ov2",  bus_a.out_valid, 0);
    bubble = 1'b0; #1;
    chk("bub_rel_req", bus_a.imem_req, 1);
    tick();
    chk("bub_rel_pc", pc_a, 32'h10);

    // drain, then switch to 3-cycle latency
    bubble = 1'b1;
    tick();
    chk("drn_opc", bus_a.out_pc, 32'hC);
    tick(); tick(); tick();
    chk("drn_ov", bus_a.out_valid, 0);
    chk("drn_pc", pc_a, 32'h10);
    lat = 3; bubble = 1'b0;
    tick();
    chk("ca1_pc", pc_a, 32'h14);
    tick();
    chk("ca2_pc",   pc_a, 32'h18);
    chk("ca2_live", 32'(u_a.live_q), 32'd2);

    // redirect with two fetches in flight
    redirect = 1'b1; redirect_pc = 32'h103; #1;
    chk("rd_req", bus_a.imem_req, 0);
    tick();
    chk("rd_pc",   pc_a, 32'h100);
    chk("rd_kill", 32'(u_a.kill_q), 32'd2);
    chk("rd_ov",   bus_a.out_valid, 0);
    redirect = 1'b0;
    tick();
    chk("rd1_pc",   pc_a, 32'h104);
    chk("rd1_kill", 32'(u_a.kill_q), 32'd1);
    chk("rd1_ov",   bus_a.out_valid, 0);
    tick();
    chk("rd2_kill", 32'(u_a.kill_q), 32'd0);
    chk("rd2_ov",   bus_a.out_valid, 0);
    tick();
    chk("rd3_ov", bus_a.out_valid, 0);
    tick();
    chk("rd4_pc",    pc_a, 32'h110);
    chk("rd4_ov",    bus_a.out_valid, 1);
    chk("rd4_opc",   bus_a.out_pc, 32'h100);
    chk("rd4_instr", bus_a.out_instr, insn_of(32'h100));

    // redirect coinciding with a response and a pop
    chk("co_rvalid", bus_a.imem_rvalid, 1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("co_pc",   pc_a, 32'h200);
    chk("co_kill", 32'(u_a.kill_q), 32'd2);
    chk("co_ov",   bus_a.out_valid, 0);
    redirect = 1'b0;
    tick();
    chk("co1_kill", 32'(u_a.kill_q), 32'd1);
    chk("co1_ov",   bus_a.out_valid, 0);
    tick();
    chk("co2_ov", bus_a.out_valid, 0);
    tick();
    chk("co3_ov", bus_a.out_valid, 0);
    tick();
    chk("co4_ov",  bus_a.out_valid, 1);
    chk("co4_opc", bus_a.out_pc, 32'h200);

    // asynchronous reset between edges
    #3 rst = 1'b0; #1;
    chk("ar_pc_a",  pc_a, 32'h0);
    chk("ar_req_a", bus_a.imem_req, 0);
    chk("ar_ov_a",  bus_a.out_valid, 0);
    chk("ar_pc_b",  pc_b, RB);
    chk("ar_ov_b",  bus_b.out_valid, 0);

    // backpressure on the DEPTH=2 instance
    lat = 1; out_ready = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("bp0_req", bus_b.imem_req, 1);
    chk("bp0_pc",  pc_b, RB);
    tick();
    chk("bp1_pc", pc_b, RB + 32'h4);
    tick();
    chk("bp2_pc",  pc_b, RB + 32'h8);
    chk("bp2_req", bus_b.imem_req, 0);
    chk("bp2_opc", bus_b.out_pc, RB);
    tick();
    chk("bp3_pc",    pc_b, RB + 32'h8);
    chk("bp3_req",   bus_b.imem_req, 0);
    chk("bp3_instr", bus_b.out_instr, insn_of(RB));
    out_ready = 1'b1;
    tick();
    chk("bp4_opc",   bus_b.out_pc, RB + 32'h4);
    chk("bp4_instr", bus_b.out_instr, insn_of(RB + 32'h4));
    chk("bp4_req",   bus_b.imem_req, 1);
    chk("bp4_pc",    pc_b, RB + 32'h8);
    tick();
    chk("bp5_pc", pc_b, RB + 32'hC);

    // PC wrap at the top of the address space
    bubble = 1'b1;
    tick(); tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    chk("wr0_pc", pc_b, 32'hFFFF_FFF8);
    chk("wr0_ov", bus_b.out_valid, 0);
    redirect = 1'b0; bubble = 1'b0;
    tick();
    chk("wr1_pc", pc_b, 32'hFFFF_FFFC);
    tick();
    chk("wr2_pc",    pc_b, 32'h0);
    chk("wr2_opc",   bus_b.out_pc, 32'hFFFF_FFF8);
    chk("wr2_instr", bus_b.out_instr, insn_of(32'hFFFF_FFF8));
    tick();
    chk("wr3_opc",   bus_b.out_pc, 32'hFFFF_FFFC);
    chk("wr3_instr", bus_b.out_instr, insn_of(32'hFFFF_FFFC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
